// File: rtl/dual_fetch_queue_if.sv
// Fetch-side and issue-side signal bundle for dual_fetch_queue.
// The queue takes the slave view; the fetch/decode driver takes the master view.
interface dual_fetch_queue_if #(
    parameter int instr_width_p = 32,
    parameter int pc_width_p    = 22
);
    logic                              flush_i;
    logic [pc_width_p-1:0]             flush_pc_i;
    logic                              fetch_v_i;
    logic                              fetch_two_i;
    logic [1:0][instr_width_p-1:0]     fetch_instr_i;
    logic                              fetch_ready_o;
    logic [pc_width_p-1:0]             fetch_pc_o;
    logic [1:0]                        issue_v_o;
    logic [1:0][instr_width_p-1:0]     issue_instr_o;
    logic [pc_width_p-1:0]             issue_pc_o;
    logic [1:0]                        issue_count_i;

    modport slave (
        input  flush_i, flush_pc_i, fetch_v_i, fetch_two_i, fetch_instr_i, issue_count_i,
        output fetch_ready_o, fetch_pc_o, issue_v_o, issue_instr_o, issue_pc_o
    );

    modport master (
        output flush_i, flush_pc_i, fetch_v_i, fetch_two_i, fetch_instr_i, issue_count_i,
        input  fetch_ready_o, fetch_pc_o, issue_v_o, issue_instr_o, issue_pc_o
    );
endinterface

// File: rtl/dual_fetch_queue.sv
// Circular instruction-pair queue between fetch and dual-issue decode.
// Accepts 1-2 words per cycle, presents the two oldest, retires 0-2 per cycle.
module dual_fetch_queue #(
    parameter int                    depth_p       = 4,
    parameter int                    instr_width_p = 32,
    parameter int                    pc_width_p    = 22,
    parameter logic [pc_width_p-1:0] boot_pc_p     = '0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    dual_fetch_queue_if.slave fq
);
    localparam int ptr_w_lp = $clog2(depth_p);

    typedef logic [ptr_w_lp-1:0] ptr_t;
    typedef logic [ptr_w_lp:0]   cnt_t;

    logic [instr_width_p-1:0] mem_r [depth_p];
    ptr_t                     rd_ptr_r, wr_ptr_r;
    cnt_t                     count_r;
    logic [pc_width_p-1:0]    issue_pc_r, fetch_pc_r;
    logic                     fetch_ready, enq_fire;
    cnt_t                     enq_n, deq_n;

    // Readiness looks only at the registered count so there is no input->output path.
    assign fetch_ready = (count_r <= cnt_t'(depth_p - 2));
    assign enq_fire    = fq.fetch_v_i & fetch_ready & ~fq.flush_i;
    assign enq_n       = enq_fire ? (fq.fetch_two_i ? cnt_t'(2) : cnt_t'(1)) : '0;
    assign deq_n       = fq.flush_i ? '0 : cnt_t'(fq.issue_count_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            issue_pc_r <= boot_pc_p;
            fetch_pc_r <= boot_pc_p;
        end else if (fq.flush_i) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            issue_pc_r <= fq.flush_pc_i;
            fetch_pc_r <= fq.flush_pc_i;
        end else begin
            rd_ptr_r   <= rd_ptr_r + ptr_t'(deq_n);
            wr_ptr_r   <= wr_ptr_r + ptr_t'(enq_n);
            count_r    <= count_r + enq_n - deq_n;
            issue_pc_r <= issue_pc_r + pc_width_p'(deq_n);
            fetch_pc_r <= fetch_pc_r + pc_width_p'(enq_n);
        end
    end

    // Storage is not reset; count_r alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem_r[wr_ptr_r] <= fq.fetch_instr_i[0];
            if (fq.fetch_two_i)
                mem_r[wr_ptr_r + ptr_t'(1)] <= fq.fetch_instr_i[1];
        end
    end

    always_comb begin
        fq.issue_v_o     = '0;
        fq.issue_instr_o = '0;
        for (int s = 0; s < 2; s++) begin
            fq.issue_v_o[s]     = (count_r > cnt_t'(s));
            fq.issue_instr_o[s] = mem_r[rd_ptr_r + ptr_t'(s)];
        end
    end

    assign fq.fetch_ready_o = fetch_ready;
    assign fq.fetch_pc_o    = fetch_pc_r;
    assign fq.issue_pc_o    = issue_pc_r;

    always_ff @(posedge clk_i) begin
        if (!reset_i && !fq.flush_i)
            assert (fq.issue_count_i != 2'd3 && cnt_t'(fq.issue_count_i) <= count_r)
                else $error("dual_fetch_queue: illegal issue_count_i=%0d with count=%0d",
                            fq.issue_count_i, count_r);
    end
endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed + randomized check of dual_fetch_queue against a queue-based model.
module tb_dual_fetch_queue;
    localparam int            DEPTH = 4;
    localparam int            IW    = 32;
    localparam int            PW    = 22;
    localparam logic [PW-1:0] BOOT  = 22'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_fetch_queue_if #(.instr_width_p(IW), .pc_width_p(PW)) dif ();

    dual_fetch_queue #(
        .depth_p(DEPTH), .instr_width_p(IW), .pc_width_p(PW), .boot_pc_p(BOOT)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .fq(dif)
    );

    // Model: the queue holds live instructions oldest-first; PCs are plain counters.
    logic [IW-1:0] mq [$];
    logic [PW-1:0] m_ipc, m_fpc;
    int nchk = 0;
    int nerr = 0;

    task automatic chk1(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk(input string tag);
        logic [1:0] ev;
        ev = {mq.size() >= 2, mq.size() >= 1};
        chk1({tag, " issue_v"}, 64'(dif.issue_v_o), 64'(ev));
        chk1({tag, " issue_pc"}, 64'(dif.issue_pc_o), 64'(m_ipc));
        chk1({tag, " fetch_pc"}, 64'(dif.fetch_pc_o), 64'(m_fpc));
        chk1({tag, " ready"}, 64'(dif.fetch_ready_o), 64'(mq.size() <= DEPTH - 2));
        if (mq.size() >= 1) chk1({tag, " slot0"}, 64'(dif.issue_instr_o[0]), 64'(mq[0]));
        if (mq.size() >= 2) chk1({tag, " slot1"}, 64'(dif.issue_instr_o[1]), 64'(mq[1]));
    endtask

    task automatic set_idle();
        dif.flush_i       = 1'b0;
        dif.flush_pc_i    = '0;
        dif.fetch_v_i     = 1'b0;
        dif.fetch_two_i   = 1'b0;
        dif.fetch_instr_i = '0;
        dif.issue_count_i = 2'd0;
    endtask

    // Apply one cycle of inputs, check the current outputs, advance the model, clock.
    task automatic cycle(input string tag, input bit v, input bit two,
                         input logic [IW-1:0] w0, input logic [IW-1:0] w1,
                         input logic [1:0] cnt, input bit fl, input logic [PW-1:0] fpc);
        bit ready;
        dif.fetch_v_i        = v;
        dif.fetch_two_i      = two;
        dif.fetch_instr_i[0] = w0;
        dif.fetch_instr_i[1] = w1;
        dif.issue_count_i    = cnt;
        dif.flush_i          = fl;
        dif.flush_pc_i       = fpc;
        chk(tag);
        ready = (mq.size() <= DEPTH - 2);
        if (fl) begin
            mq.delete();
            m_ipc = fpc;
            m_fpc = fpc;
        end else begin
            for (int k = 0; k < int'(cnt); k++) void'(mq.pop_front());
            m_ipc = m_ipc + PW'(cnt);
            if (v && ready) begin
                mq.push_back(w0);
                if (two) mq.push_back(w1);
                m_fpc = m_fpc + (two ? PW'(2) : PW'(1));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycles(input int n, input bit allow_flush);
        for (int i = 0; i < n; i++) begin
            int e, dmax, d;
            bit fl;
            e    = $urandom_range(0, 2);
            dmax = (mq.size() < 2) ? mq.size() : 2;
            d    = $urandom_range(0, dmax);
            fl   = allow_flush && ($urandom_range(0, 31) == 0);
            cycle("rand", e != 0, e == 2, $urandom, $urandom, 2'(d), fl, PW'($urandom));
        end
    endtask

    initial begin
        set_idle();
        m_ipc = BOOT;
        m_fpc = BOOT;

        // Reset values
        @(posedge clk);
        #1;
        chk("reset");
        chk1("reset_v", 64'(dif.issue_v_o), 64'(2'b00));
        chk1("reset_pc", 64'(dif.issue_pc_o), 64'(22'h100));
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill the queue, then a dropped third fetch
        cycle("fill0", 1, 1, 32'hA, 32'hB, 0, 0, '0);
        cycle("fill1", 1, 1, 32'hC, 32'hD, 0, 0, '0);
        chk1("full_ready", 64'(dif.fetch_ready_o), 64'(0));
        chk1("full_fpc", 64'(dif.fetch_pc_o), 64'(22'h104));
        cycle("drop", 1, 1, 32'hE, 32'hF, 0, 0, '0);

        // Mixed retire from full
        chk1("ret_a", 64'(dif.issue_instr_o[0]), 64'(32'hA));
        cycle("ret1", 0, 0, '0, '0, 2'd1, 0, '0);
        chk1("ret_b", 64'(dif.issue_instr_o[0]), 64'(32'hB));
        chk1("ret_c", 64'(dif.issue_instr_o[1]), 64'(32'hC));
        chk1("ret_pc", 64'(dif.issue_pc_o), 64'(22'h101));
        cycle("ret2", 0, 0, '0, '0, 2'd2, 0, '0);
        chk("tail");
        chk1("tail_v", 64'(dif.issue_v_o), 64'(2'b01));
        chk1("tail_pc", 64'(dif.issue_pc_o), 64'(22'h103));
        chk1("tail_d", 64'(dif.issue_instr_o[0]), 64'(32'hD));

        // Wrap with simultaneous random traffic
        rand_cycles(200, 1'b1);

        // Flush with same-cycle enqueue and dequeue
        for (int i = 0; i < 3 && mq.size() < 2; i++)
            cycle("pre_flush", 1, 1, $urandom, $urandom, 0, 0, '0);
        cycle("flush", 1, 1, 32'h1111, 32'h2222, 2'd2, 1, 22'h2A0);
        chk("post_flush");
        chk1("flush_v", 64'(dif.issue_v_o), 64'(2'b00));
        chk1("flush_ipc", 64'(dif.issue_pc_o), 64'(22'h2A0));
        chk1("flush_fpc", 64'(dif.fetch_pc_o), 64'(22'h2A0));
        cycle("refetch", 1, 0, 32'h3333, '0, 0, 0, '0);
        chk1("refetch_instr", 64'(dif.issue_instr_o[0]), 64'(32'h3333));
        chk1("refetch_v", 64'(dif.issue_v_o), 64'(2'b01));

        // Async reset mid-cycle with three entries live
        cycle("to3", 1, 1, 32'h4444, 32'h5555, 0, 0, '0);
        set_idle();
        chk1("three_v", 64'(dif.issue_v_o), 64'(2'b11));
        #2 rst = 1'b1;
        #1;
        mq.delete();
        m_ipc = BOOT;
        m_fpc = BOOT;
        chk("async_rst");
        chk1("async_v", 64'(dif.issue_v_o), 64'(2'b00));
        chk1("async_ready", 64'(dif.fetch_ready_o), 64'(1));
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        rand_cycles(40, 1'b0);
        set_idle();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
